// File: rtl/issue_select.sv
// rtl/issue_select.sv - oldest-first hazard-checked issue select with register scoreboard
module issue_select #(
  parameter int DEPTH     = 4,
  parameter int NUM_UNITS = 4,
  localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DEPTH-1:0]       valid,
  input  logic [DEPTH*5-1:0]     rs1,
  input  logic [DEPTH*5-1:0]     rs2,
  input  logic [DEPTH*5-1:0]     rd,
  input  logic [DEPTH-1:0]       uses_rs1,
  input  logic [DEPTH-1:0]       uses_rs2,
  input  logic [DEPTH-1:0]       uses_rd,
  input  logic [DEPTH*UW-1:0]    unit,
  input  logic [NUM_UNITS-1:0]   unit_ready,
  input  logic                   flush,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_rd,
  output logic [DEPTH-1:0]       pop,
  output logic                   issue_valid,
  output logic [IW-1:0]          issue_index,
  output logic [NUM_UNITS-1:0]   issue_unit,
  output logic [31:0]            rd_busy
);

  logic [31:0]      busy;
  logic [31:0]      busy_next;
  logic [4:0]       s1 [DEPTH];
  logic [4:0]       s2 [DEPTH];
  logic [4:0]       d  [DEPTH];
  logic [UW-1:0]    u  [DEPTH];
  logic [DEPTH-1:0] rd1;
  logic [DEPTH-1:0] rd2;
  logic [DEPTH-1:0] wr;
  logic [DEPTH-1:0] elig;
  logic             ok;
  logic             found;
  logic [IW-1:0]    sel;
  logic [UW-1:0]    sel_unit;
  logic             set_en;
  logic [4:0]       set_rd;

  // Reads/writes of x0 are treated as absent so they never create hazards.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      s1[i]  = rs1[5*i +: 5];
      s2[i]  = rs2[5*i +: 5];
      d[i]   = rd[5*i +: 5];
      u[i]   = unit[UW*i +: UW];
      rd1[i] = uses_rs1[i] && (s1[i] != 5'd0);
      rd2[i] = uses_rs2[i] && (s2[i] != 5'd0);
      wr[i]  = uses_rd[i] && (d[i] != 5'd0);
    end
  end

  always_comb begin
    elig = '0;
    ok   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ok = valid[i] && !flush && !rst && (int'(u[i]) < NUM_UNITS) && unit_ready[u[i]];
      if (rd1[i] && busy[s1[i]]) ok = 1'b0;
      if (rd2[i] && busy[s2[i]]) ok = 1'b0;
      if (wr[i] && busy[d[i]])   ok = 1'b0;
      // Any valid older entry may still be waiting, so its register use orders this one.
      for (int j = i + 1; j < DEPTH; j++) begin
        if (valid[j]) begin
          if (wr[j] && ((rd1[i] && s1[i] == d[j]) || (rd2[i] && s2[i] == d[j]))) ok = 1'b0;
          if (wr[i] && ((rd1[j] && s1[j] == d[i]) || (rd2[j] && s2[j] == d[i]))) ok = 1'b0;
          if (wr[i] && wr[j] && d[i] == d[j]) ok = 1'b0;
        end
      end
      elig[i] = ok;
    end
  end

  always_comb begin
    found    = 1'b0;
    sel      = '0;
    sel_unit = '0;
    set_en   = 1'b0;
    set_rd   = 5'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (elig[i]) begin
        found    = 1'b1;
        sel      = IW'(i);
        sel_unit = u[i];
        set_en   = wr[i];
        set_rd   = d[i];
      end
    end
  end

  assign issue_valid = found;
  assign issue_index = sel;
  assign pop         = found ? (DEPTH'(1) << sel) : '0;
  assign issue_unit  = found ? (NUM_UNITS'(1) << sel_unit) : '0;
  assign rd_busy     = busy;

  // Set is applied after clear so an issue wins over a same-edge writeback.
  always_comb begin
    busy_next = busy;
    if (wb_valid) busy_next[wb_rd] = 1'b0;
    if (found && set_en) busy_next[set_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

endmodule

// File: tb/tb_issue_select.sv
// tb/tb_issue_select.sv - directed and random checks of issue_select against a reference model
module tb_issue_select;
  localparam int DEPTH = 4;
  localparam int NUM_UNITS = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [DEPTH-1:0]     valid, uses_rs1, uses_rs2, uses_rd;
  logic [DEPTH*5-1:0]   rs1, rs2, rd;
  logic [DEPTH*2-1:0]   unit;
  logic [NUM_UNITS-1:0] unit_ready;
  logic                 flush, wb_valid;
  logic [4:0]           wb_rd;
  logic [DEPTH-1:0]     pop;
  logic                 issue_valid;
  logic [1:0]           issue_index;
  logic [NUM_UNITS-1:0] issue_unit;
  logic [31:0]          rd_busy;

  typedef struct {
    bit v, u1, u2, ud;
    int r1, r2, d, un;
  } ent_t;

  ent_t e[DEPTH];
  bit   mbusy[32];
  int   passed = 0;
  int   total = 0;
  int   fails = 0;

  issue_select #(.DEPTH(DEPTH), .NUM_UNITS(NUM_UNITS)) dut (
    .clk(clk), .rst(rst), .valid(valid), .rs1(rs1), .rs2(rs2), .rd(rd),
    .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .uses_rd(uses_rd), .unit(unit),
    .unit_ready(unit_ready), .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .pop(pop), .issue_valid(issue_valid), .issue_index(issue_index),
    .issue_unit(issue_unit), .rd_busy(rd_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit reads(ent_t x, int r);
    return r != 0 && ((x.u1 && x.r1 == r) || (x.u2 && x.r2 == r));
  endfunction

  function automatic int wreg(ent_t x);
    return x.ud ? x.d : 0;
  endfunction

  function automatic int pick();
    bit ok;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      ok = e[i].v && unit_ready[e[i].un] && !flush && !rst;
      if ((e[i].u1 && mbusy[e[i].r1]) || (e[i].u2 && mbusy[e[i].r2])) ok = 0;
      if (mbusy[wreg(e[i])]) ok = 0;
      for (int j = i + 1; j < DEPTH; j++) begin
        if (e[j].v) begin
          if (reads(e[i], wreg(e[j])) || reads(e[j], wreg(e[i]))) ok = 0;
          if (wreg(e[i]) != 0 && wreg(e[i]) == wreg(e[j])) ok = 0;
        end
      end
      if (ok) return i;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = e[i].v;
      uses_rs1[i] = e[i].u1;
      uses_rs2[i] = e[i].u2;
      uses_rd[i] = e[i].ud;
      rs1[5*i +: 5] = 5'(e[i].r1);
      rs2[5*i +: 5] = 5'(e[i].r2);
      rd[5*i +: 5] = 5'(e[i].d);
      unit[2*i +: 2] = 2'(e[i].un);
    end
  endtask

  // Called at posedge+1; checks just before the next edge, then advances the model.
  task automatic step(int want_pop);
    int k;
    logic [31:0] exp_busy;
    drive();
    #4;
    k = pick();
    for (int r = 0; r < 32; r++) exp_busy[r] = mbusy[r];
    chk("pop", 32'(pop), (k >= 0) ? (32'd1 << k) : 32'd0);
    chk("issue_valid", 32'(issue_valid), (k >= 0) ? 32'd1 : 32'd0);
    chk("issue_index", 32'(issue_index), (k >= 0) ? 32'(k) : 32'd0);
    chk("issue_unit", 32'(issue_unit), (k >= 0) ? (32'd1 << e[k].un) : 32'd0);
    chk("rd_busy", rd_busy, exp_busy);
    if (want_pop >= 0) chk("directed_pop", 32'(pop), 32'(want_pop));
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < 32; r++) mbusy[r] = 0;
    end else begin
      if (wb_valid) mbusy[wb_rd] = 0;
      if (k >= 0 && wreg(e[k]) != 0) mbusy[wreg(e[k])] = 1;
    end
    #1;
  endtask

  task automatic clear();
    for (int i = 0; i < DEPTH; i++) e[i] = '{0, 0, 0, 0, 0, 0, 0, 0};
    flush = 0;
    wb_valid = 0;
    wb_rd = 0;
    unit_ready = 4'hF;
  endtask

  task automatic set_ent(int i, bit u1, int r1, bit u2, int r2, bit ud, int d, int un);
    e[i] = '{1, u1, u2, ud, r1, r2, d, un};
  endtask

  initial begin
    for (int r = 0; r < 32; r++) mbusy[r] = 0;
    clear();
    rst = 1;
    for (int i = 0; i < DEPTH; i++) set_ent(i, 0, 0, 0, 0, 1, i + 1, 0);
    @(posedge clk);
    #1;
    step(0);
    step(0);
    chk("reset_busy", rd_busy, 32'd0);
    rst = 0;

    clear();
    set_ent(3, 0, 0, 0, 0, 1, 5, 0);
    step(4'b1000);
    chk("t1_busy5", 32'(rd_busy[5]), 32'd1);

    clear();
    set_ent(3, 1, 5, 0, 0, 0, 0, 0);
    step(4'b0000);
    wb_valid = 1; wb_rd = 5;
    step(4'b0000);
    wb_valid = 0;
    step(4'b1000);

    clear();
    set_ent(3, 0, 0, 0, 0, 1, 7, 1);
    set_ent(2, 0, 0, 1, 7, 0, 0, 0);
    unit_ready = 4'b1101;
    step(4'b0000);
    set_ent(1, 0, 0, 0, 0, 1, 9, 0);
    step(4'b0010);

    clear();
    set_ent(3, 0, 0, 0, 0, 1, 4, 0);
    step(4'b1000);
    clear();
    set_ent(3, 1, 4, 0, 0, 0, 0, 0);
    set_ent(2, 0, 0, 0, 0, 1, 4, 0);
    step(4'b0000);
    set_ent(2, 0, 0, 0, 0, 1, 0, 2);
    step(4'b0100);
    chk("x0_never_busy", 32'(rd_busy[0]), 32'd0);

    clear();
    wb_valid = 1; wb_rd = 6;
    set_ent(3, 0, 0, 0, 0, 1, 6, 3);
    step(4'b1000);
    chk("t5_set_wins", 32'(rd_busy[6]), 32'd1);

    clear();
    for (int i = 0; i < DEPTH; i++) set_ent(i, 0, 0, 0, 0, 1, 20 + i, i);
    step(4'b1000);
    unit_ready = 4'b0001;
    for (int i = 1; i < DEPTH; i++) e[i].un = 1;
    step(4'b0001);
    unit_ready = 4'b0000;
    step(4'b0000);

    unit_ready = 4'hF;
    flush = 1;
    step(4'b0000);
    flush = 0;
    rst = 1;
    wb_valid = 1; wb_rd = 21;
    step(4'b0000);
    chk("rst_busy_cleared", rd_busy, 32'd0);
    rst = 0;
    wb_valid = 1; wb_rd = 6;
    clear();
    wb_valid = 1; wb_rd = 6;
    step(4'b0000);

    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < DEPTH; i++)
        e[i] = '{$urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 3)};
      unit_ready = 4'($urandom_range(0, 15));
      flush = ($urandom_range(0, 15) == 0);
      wb_valid = $urandom_range(0, 1);
      wb_rd = 5'($urandom_range(0, 7));
      rst = ($urandom_range(0, 63) == 0);
      step(-1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
